// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: ICACHE (m0) and DCACHE (m1) share one read channel.
// Round-robin address grant, one burst in flight, R channel locked to the winner until RLAST.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int AXI_ID_WIDTH = 4,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // requester 0 (ICACHE refill)
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    input  logic [LEN_WIDTH-1:0]    m0_arlen,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]              m0_rresp,
    output logic                    m0_rlast,
    // requester 1 (DCACHE refill)
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    input  logic [LEN_WIDTH-1:0]    m1_arlen,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]              m1_rresp,
    output logic                    m1_rlast,
    // memory side
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic [LEN_WIDTH-1:0]    axi_arlen,
    output logic [2:0]              axi_arsize,
    output logic [1:0]              axi_arburst,
    output logic [AXI_ID_WIDTH-1:0] axi_arid,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    output logic                    len_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    logic [1:0]            state;
    logic                  grant;
    logic                  rr_ptr;
    logic                  live;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;

    logic winner;
    logic in_idle;
    logic in_data;
    logic req_hs;
    logic beat;
    logic len_bad;

    // live keeps both arready outputs low while reset is held, without using
    // rst_n itself as a data signal.
    assign in_idle = (state == S_IDLE) && live;
    assign in_data = (state == S_DATA);

    // Tie goes to rr_ptr; a lone requester always wins.
    assign winner = (m0_arvalid && m1_arvalid) ? rr_ptr : m1_arvalid;
    assign req_hs = in_idle && (m0_arvalid || m1_arvalid);

    assign m0_arready = in_idle && m0_arvalid && !winner;
    assign m1_arready = in_idle && m1_arvalid &&  winner;

    assign axi_arvalid = (state == S_ADDR);
    assign axi_araddr  = addr_q;
    assign axi_arlen   = len_q;
    assign axi_arsize  = AXI_SIZE_4B;
    assign axi_arburst = AXI_BURST_INCR;
    assign axi_arid    = {{(AXI_ID_WIDTH-1){1'b0}}, grant};

    // R channel: data bus is shared, only the granted requester sees rvalid.
    assign m0_rvalid  = in_data && !grant && axi_rvalid;
    assign m1_rvalid  = in_data &&  grant && axi_rvalid;
    assign m0_rdata   = axi_rdata;
    assign m1_rdata   = axi_rdata;
    assign m0_rresp   = axi_rresp;
    assign m1_rresp   = axi_rresp;
    assign m0_rlast   = axi_rlast;
    assign m1_rlast   = axi_rlast;
    assign axi_rready = in_data && (grant ? m1_rready : m0_rready);

    assign beat    = axi_rvalid && axi_rready;
    assign len_bad = axi_rlast ? (beat_cnt != len_q) : (beat_cnt == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grant    <= 1'b0;
            rr_ptr   <= 1'b0;
            live     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_hs) begin
                        grant  <= winner;
                        addr_q <= winner ? m1_araddr : m0_araddr;
                        len_q  <= winner ? m1_arlen  : m0_arlen;
                        state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (axi_arready) begin
                        beat_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (len_bad)
                            len_err <= 1'b1;
                        // the slave's RLAST is authoritative for ending the burst
                        if (axi_rlast) begin
                            rr_ptr <= ~grant;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a scripted memory slave plus two scripted requesters,
// one task per scenario with inline checks against hand-computed values.
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [AW-1:0] m0_araddr;
    logic [LW-1:0] m0_arlen;
    logic [DW-1:0] m0_rdata;
    logic [1:0]    m0_rresp;
    logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [AW-1:0] m1_araddr;
    logic [LW-1:0] m1_arlen;
    logic [DW-1:0] m1_rdata;
    logic [1:0]    m1_rresp;
    logic          axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast, len_err;
    logic [AW-1:0] axi_araddr;
    logic [LW-1:0] axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst, axi_rresp;
    logic [IW-1:0] axi_arid;
    logic [DW-1:0] axi_rdata;

    axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arid(axi_arid),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // beats delivered to each requester, appended by the monitor
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          l0[$];
    logic [1:0]    rs0[$];
    int            last0_cnt = 0;
    int            rv1_cnt   = 0;

    // slave-side record of the last burst
    logic [IW-1:0] s_id;
    logic [AW-1:0] s_addr;
    logic [LW-1:0] s_len;
    int            s_arv_cyc, s_last_cyc;
    int            hs_cyc[2];
    bit            abort;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (m0_rvalid && m0_rready) begin
            q0.push_back(m0_rdata);
            l0.push_back(m0_rlast);
            rs0.push_back(m0_rresp);
            if (m0_rlast) last0_cnt++;
        end
        if (m1_rvalid && m1_rready) q1.push_back(m1_rdata);
        if (m1_rvalid) rv1_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input bit idx, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int t;
        bit got;
        if (idx) begin m1_araddr = a; m1_arlen = l; m1_arvalid = 1'b1; end
        else     begin m0_araddr = a; m0_arlen = l; m0_arvalid = 1'b1; end
        t = 0; got = 0;
        while (!got && t < 300) begin
            @(negedge clk);
            got = idx ? m1_arready : m0_arready;
            if (got) hs_cyc[idx] = cyc;
            @(posedge clk); #1;
            t++;
        end
        if (idx) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL req%0d_arready: no grant after %0d cycles, want grant", idx, t); end
    endtask

    // Memory slave: accepts one address, returns beats base+i with rlast on index last_at,
    // SLVERR on beat 2, honouring axi_rready.
    task automatic slave_burst(input int last_at, input logic [DW-1:0] base);
        int t;
        bit acc;
        t = 0;
        while (!axi_arvalid && t < 300 && !abort) begin @(posedge clk); #1; t++; end
        if (!axi_arvalid) begin
            if (!abort) begin
                n_cmp++; n_bad++;
                $display("FAIL slave_arvalid: axi_arvalid=0 after %0d cycles, want 1", t);
            end
            return;
        end
        s_id = axi_arid; s_addr = axi_araddr; s_len = axi_arlen; s_arv_cyc = cyc;
        axi_arready = 1'b1;
        @(posedge clk); #1;
        axi_arready = 1'b0;
        for (int i = 0; i <= last_at; i++) begin
            axi_rvalid = 1'b1;
            axi_rdata  = base + DW'(i);
            axi_rlast  = (i == last_at);
            axi_rresp  = (i == 2) ? 2'b10 : 2'b00;
            t = 0; acc = 0;
            while (!acc && t < 300 && !abort) begin
                @(negedge clk);
                acc = axi_rready;
                if (acc && i == last_at) s_last_cyc = cyc;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) begin
                if (!abort) begin
                    n_cmp++; n_bad++;
                    $display("FAIL slave_rready: beat %0d not accepted after %0d cycles", i, t);
                end
                break;
            end
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid: got %b want 0", axi_arvalid); end
        n_cmp++; if (axi_rready  !== 1'b0) begin n_bad++; $display("FAIL rst_rready: got %b want 0", axi_rready); end
        n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        n_cmp++; if ({axi_araddr, axi_arlen, axi_arid} !== '0) begin n_bad++; $display("FAIL rst_ar_regs: got %h/%h/%h want 0", axi_araddr, axi_arlen, axi_arid); end
        n_cmp++; if (axi_arsize !== 3'b010) begin n_bad++; $display("FAIL rst_arsize: got %b want 010", axi_arsize); end
        n_cmp++; if (axi_arburst !== 2'b01) begin n_bad++; $display("FAIL rst_arburst: got %b want 01", axi_arburst); end
        n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL rst_len_err: got %b want 0", len_err); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_m0();
        int b0, rv1;
        logic [DW-1:0] want;
        b0 = q0.size(); rv1 = rv1_cnt;
        fork
            do_req(1'b0, 32'h100, 8'd7);
            slave_burst(7, 32'hA0);
        join
        n_cmp++; if (s_id !== 4'd0) begin n_bad++; $display("FAIL t1_arid: got %h want 0", s_id); end
        n_cmp++; if (s_addr !== 32'h100 || s_len !== 8'd7) begin n_bad++; $display("FAIL t1_addr_len: got %h/%0d want 100/7", s_addr, s_len); end
        n_cmp++; if (s_arv_cyc !== hs_cyc[0] + 1) begin n_bad++; $display("FAIL t1_latency: arvalid cycle %0d want %0d", s_arv_cyc, hs_cyc[0] + 1); end
        n_cmp++; if (q0.size() !== b0 + 8) begin n_bad++; $display("FAIL t1_beats: got %0d want 8", q0.size() - b0); end
        for (int i = 0; i < 8 && b0 + i < q0.size(); i++) begin
            want = 32'hA0 + DW'(i);
            n_cmp++; if (q0[b0+i] !== want || l0[b0+i] !== (i == 7)) begin
                n_bad++; $display("FAIL t1_beat%0d: got %h last %b want %h last %b", i, q0[b0+i], l0[b0+i], want, i == 7);
            end
        end
        if (q0.size() > b0 + 2) begin
            n_cmp++; if (rs0[b0+2] !== 2'b10) begin n_bad++; $display("FAIL t1_rresp: got %b want 10", rs0[b0+2]); end
        end
        n_cmp++; if (rv1_cnt !== rv1) begin n_bad++; $display("FAIL t1_m1_rvalid: saw %0d beats want 0", rv1_cnt - rv1); end
    endtask

    task automatic test_tie_rr();
        logic [IW-1:0] id_a, id_b, id_c, id_d;
        logic [AW-1:0] ad_a, ad_b;
        int b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        b1 = q1.size();
        fork
            do_req(1'b0, 32'h200, 8'd2);
            do_req(1'b1, 32'h300, 8'd2);
            begin
                slave_burst(2, 32'h10); id_a = s_id; ad_a = s_addr;
                slave_burst(2, 32'h20); id_b = s_id; ad_b = s_addr;
            end
        join
        fork
            do_req(1'b0, 32'h400, 8'd1);
            do_req(1'b1, 32'h500, 8'd1);
            begin
                slave_burst(1, 32'h30); id_c = s_id;
                slave_burst(1, 32'h40); id_d = s_id;
            end
        join
        n_cmp++; if (id_a !== 4'd0 || ad_a !== 32'h200) begin n_bad++; $display("FAIL t2_first: id %h addr %h want 0/200", id_a, ad_a); end
        n_cmp++; if (id_b !== 4'd1 || ad_b !== 32'h300) begin n_bad++; $display("FAIL t2_second: id %h addr %h want 1/300", id_b, ad_b); end
        n_cmp++; if (id_c !== 4'd0 || id_d !== 4'd1) begin n_bad++; $display("FAIL t2_next_tie: ids %h,%h want 0,1", id_c, id_d); end
        n_cmp++; if (q1.size() < b1 + 3 || q1[b1] !== 32'h20 || q1[b1+2] !== 32'h22) begin
            n_bad++; $display("FAIL t2_m1_data: got %0d beats want 3 beats 20..22", q1.size() - b1);
        end
    endtask

    task automatic test_late_req();
        int b0, l0c, t, last_m0;
        bit early;
        b0 = q0.size(); l0c = last0_cnt; early = 0;
        fork
            do_req(1'b0, 32'h600, 8'd7);
            slave_burst(7, 32'h50);
            begin
                t = 0;
                while (q0.size() < b0 + 3 && t < 300) begin @(posedge clk); #1; t++; end
                fork
                    do_req(1'b1, 32'h700, 8'd3);
                    begin
                        t = 0;
                        while (last0_cnt == l0c && t < 300) begin
                            @(negedge clk);
                            if (m1_arready) early = 1;
                            @(posedge clk); #1;
                            t++;
                        end
                    end
                join
            end
        join
        last_m0 = s_last_cyc;
        slave_burst(3, 32'h60);
        n_cmp++; if (early) begin n_bad++; $display("FAIL t3_m1_arready: got 1 during m0 burst want 0"); end
        n_cmp++; if (hs_cyc[1] !== last_m0 + 1) begin n_bad++; $display("FAIL t3_m1_grant: cycle %0d want %0d", hs_cyc[1], last_m0 + 1); end
        n_cmp++; if (s_arv_cyc !== last_m0 + 2) begin n_bad++; $display("FAIL t3_m1_arvalid: cycle %0d want %0d", s_arv_cyc, last_m0 + 2); end
        n_cmp++; if (s_id !== 4'd1 || s_addr !== 32'h700) begin n_bad++; $display("FAIL t3_m1_ar: id %h addr %h want 1/700", s_id, s_addr); end
    endtask

    task automatic test_backpressure();
        int b0, t, bad_rdy;
        logic [DW-1:0] want;
        b0 = q0.size(); bad_rdy = 0;
        fork
            do_req(1'b0, 32'h180, 8'd7);
            slave_burst(7, 32'hC0);
            begin
                t = 0;
                while (q0.size() < b0 + 4 && t < 300) begin @(posedge clk); #1; t++; end
                m0_rready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (axi_rready !== 1'b0) bad_rdy++;
                end
                @(posedge clk); #1;
                m0_rready = 1'b1;
            end
        join
        n_cmp++; if (bad_rdy != 0) begin n_bad++; $display("FAIL t4_axi_rready: high in %0d stall cycles want 0", bad_rdy); end
        n_cmp++; if (q0.size() !== b0 + 8) begin n_bad++; $display("FAIL t4_beats: got %0d want 8", q0.size() - b0); end
        for (int i = 4; i < 8 && b0 + i < q0.size(); i++) begin
            want = 32'hC0 + DW'(i);
            n_cmp++; if (q0[b0+i] !== want) begin n_bad++; $display("FAIL t4_beat%0d: got %h want %h", i, q0[b0+i], want); end
        end
    endtask

    task automatic test_len_err();
        int b0, b1;
        n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL t5_len_err_pre: got %b want 0", len_err); end
        b0 = q0.size();
        fork
            do_req(1'b0, 32'h800, 8'd7);
            slave_burst(3, 32'h90);
        join
        n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL t5_len_err_set: got %b want 1", len_err); end
        n_cmp++; if (q0.size() !== b0 + 4) begin n_bad++; $display("FAIL t5_short_beats: got %0d want 4", q0.size() - b0); end
        b1 = q1.size();
        fork
            do_req(1'b1, 32'h900, 8'd3);
            slave_burst(3, 32'hB0);
        join
        n_cmp++; if (s_id !== 4'd1 || s_len !== 8'd3) begin n_bad++; $display("FAIL t5_next_ar: id %h len %0d want 1/3", s_id, s_len); end
        n_cmp++; if (q1.size() !== b1 + 4 || q1[b1+3] !== 32'hB3) begin n_bad++; $display("FAIL t5_next_beats: got %0d beats want 4 ending B3", q1.size() - b1); end
        n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL t5_len_err_sticky: got %b want 1", len_err); end
    endtask

    task automatic test_mid_reset();
        int b1, t;
        logic [IW-1:0] id_a;
        logic [AW-1:0] ad_a;
        b1 = q1.size();
        fork
            do_req(1'b1, 32'hA00, 8'd7);
            slave_burst(7, 32'hD0);
            begin
                t = 0;
                while (q1.size() < b1 + 5 && t < 300) begin @(posedge clk); #1; t++; end
                #1;
                n_cmp++; if (m1_rvalid !== 1'b1) begin n_bad++; $display("FAIL t6_beat5_live: m1_rvalid %b want 1", m1_rvalid); end
                rst_n = 1'b0;
                m0_araddr = 32'hB00; m0_arlen = 8'd1; m0_arvalid = 1'b1;
                m1_arvalid = 1'b1;
                #1;
                n_cmp++; if ({m0_rvalid, m1_rvalid, axi_rready, axi_arvalid} !== 4'b0000) begin
                    n_bad++; $display("FAIL t6_rst_valid: rv0 %b rv1 %b rrdy %b arv %b want 0000", m0_rvalid, m1_rvalid, axi_rready, axi_arvalid);
                end
                n_cmp++; if ({m0_arready, m1_arready} !== 2'b00) begin n_bad++; $display("FAIL t6_rst_arready: got %b want 00", {m0_arready, m1_arready}); end
                n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL t6_rst_len_err: got %b want 0", len_err); end
                abort = 1'b1;
            end
        join
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fork
            do_req(1'b0, 32'hB00, 8'd1);
            do_req(1'b1, 32'hC00, 8'd1);
            begin
                slave_burst(1, 32'hE0); id_a = s_id; ad_a = s_addr;
                slave_burst(1, 32'hF0);
            end
        join
        n_cmp++; if (id_a !== 4'd0 || ad_a !== 32'hB00) begin n_bad++; $display("FAIL t6_after_rst: id %h addr %h want 0/B00", id_a, ad_a); end
        n_cmp++; if (s_id !== 4'd1) begin n_bad++; $display("FAIL t6_after_rst_m1: id %h want 1", s_id); end
    endtask

    initial begin
        m0_arvalid = 0; m0_araddr = '0; m0_arlen = '0; m0_rready = 1;
        m1_arvalid = 0; m1_araddr = '0; m1_arlen = '0; m1_rready = 1;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 0;
        abort = 0;
        test_reset();
        test_single_m0();
        test_tie_rr();
        test_late_req();
        test_backpressure();
        test_len_err();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
